// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
// Default geometry and the action encodings chosen by the priority select.
package pc_unit_pkg;

  localparam int          PC_AW        = 8;
  localparam logic [7:0]  PC_RESET_VEC = 8'h00;
  localparam logic [7:0]  PC_INC       = 8'h01;
  localparam int          PC_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_ACT_HOLD = 3'd0,
    PC_ACT_INC  = 3'd1,
    PC_ACT_BR   = 3'd2,
    PC_ACT_JMP  = 3'd3,
    PC_ACT_CALL = 3'd4,
    PC_ACT_RET  = 3'd5
  } pc_act_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: newest entry sits below the write pointer.
// When full, a push overwrites the oldest slot; ovf/unf are sticky until reset.
module pc_ras #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top_data,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          unf
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign top_data = mem_q[ptr_q - PW'(1)];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (pop) begin
      if (empty) begin
        unf_d = 1'b1;
      end else begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - (PW+1)'(1);
      end
    end else if (push) begin
      ptr_d = ptr_q + PW'(1);
      if (full) ovf_d = 1'b1;
      else      cnt_d = cnt_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: stall, branch, jump, call and return.
// One action wins per edge; the RAS is only touched by the winning call/return.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int            AW        = PC_AW,
  parameter logic [AW-1:0] RESET_VEC = PC_RESET_VEC,
  parameter logic [AW-1:0] INC       = PC_INC,
  parameter int            RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_offset,
  input  logic          jmp_en,
  input  logic          call_en,
  input  logic          ret_en,
  input  logic [AW-1:0] jmp_target,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_next,
  output logic          ras_empty,
  output logic          ras_full,
  output logic          ras_ovf,
  output logic          ras_unf
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] ras_top;
  logic          ras_push;
  logic          ras_pop;
  pc_act_e       act;

  assign pc_inc = pc_q + INC;

  always_comb begin
    act = PC_ACT_INC;
    if (stall)         act = PC_ACT_HOLD;
    else if (ret_en)   act = ras_empty ? PC_ACT_INC : PC_ACT_RET;
    else if (call_en)  act = PC_ACT_CALL;
    else if (jmp_en)   act = PC_ACT_JMP;
    else if (br_taken) act = PC_ACT_BR;
  end

  // Pop is raised even on an empty stack so the RAS can flag underflow.
  assign ras_pop  = !stall && ret_en;
  assign ras_push = (act == PC_ACT_CALL);

  always_comb begin
    pc_d = pc_q;
    unique case (act)
      PC_ACT_HOLD: pc_d = pc_q;
      PC_ACT_INC:  pc_d = pc_inc;
      PC_ACT_BR:   pc_d = pc_q + br_offset;
      PC_ACT_JMP:  pc_d = jmp_target;
      PC_ACT_CALL: pc_d = jmp_target;
      PC_ACT_RET:  pc_d = ras_top;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_VEC;
    else     pc_q <= pc_d;
  end

  assign pc_out  = pc_q;
  assign pc_next = pc_d;

  pc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule
